sgpr_restore: RTL and testbench
===============================

# sgpr_restore

Recovery sequencer on the read side of the shared comparing GPR file. When the write comparator flags a mismatch between the two lockstep cores, this block halts both cores, reads every architectural register (x1..x31) back from the shared GPR and replays it into the cores' local register files over a write port with ready handshake. It sits between the comparator's mismatch output, the shared GPR read port, and the cores' restore/halt inputs.

## Interface

- NUM_REGS, 32, number of architectural registers; x0 never restored
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, $clog2(NUM_REGS), register address width
- CNT_WIDTH, 8, width of saturating recovery counter

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- error_i  in  1  comparator mismatch flag, sampled each clk
- halt_ack_i  in  1  both cores confirm halted
- raddr_o  out  ADDR_WIDTH  shared GPR read address
- rdata_i  in  DATA_WIDTH  shared GPR read data, valid one cycle after raddr_o
- we_o  out  1  restore write valid
- waddr_o  out  ADDR_WIDTH  restore write address
- wdata_o  out  DATA_WIDTH  restore write data
- wr_ready_i  in  1  cores accept restore write
- halt_o  out  1  hold both cores
- busy_o  out  1  sequence in progress (state != IDLE)
- done_o  out  1  one-cycle pulse, restore finished
- rec_count_o  out  CNT_WIDTH  completed restores, saturating

## Operation

- States: IDLE, HALT, READ, CAPTURE, WRITE, DONE.
- IDLE: all strobes low. error_i=1 -> HALT; idx <= 1.
- HALT: halt_o=1; wait for halt_ack_i=1 -> READ.
- READ: raddr_o=idx, one cycle -> CAPTURE.
- CAPTURE: rdata_i registered into wdata_q at end of cycle -> WRITE.
- WRITE: we_o=1, waddr_o=idx, wdata_o=wdata_q; held stable until wr_ready_i=1. On acceptance: idx==NUM_REGS-1 -> DONE, else idx+1 -> READ.
- DONE: done_o=1 for one cycle; rec_count_o increments (saturates at all-ones). If pending_q set -> HALT with idx<=1 and pending_q cleared; else -> IDLE.
- error_i=1 in any state other than IDLE sets pending_q; sequence is never aborted, a second full pass follows.
- halt_o=1 in every state except IDLE; deasserts the cycle after DONE when no pending error.
- x0 never read or written.

## Timing

- Reset values: state IDLE, idx 1, raddr_o 0, we_o 0, waddr_o 0, wdata_o 0, halt_o 0, busy_o 0, done_o 0, rec_count_o 0, pending_q 0.
- rst mid-sequence: next cycle all outputs at reset values, pending error discarded.
- Error at cycle 0 (IDLE), halt_ack_i and wr_ready_i tied high: HALT cycle 1, READ x1 cycle 2, WRITE x1 cycle 4, WRITE x31 cycle 94, DONE cycle 95, halt_o low cycle 96.
- Per-register cost: 3 cycles + wr_ready_i stall cycles.
- we_o/waddr_o/wdata_o must not change while we_o=1 and wr_ready_i=0.
- All outputs registered or decoded from state/idx only; no combinational input-to-output paths.

## Structure

- Package sgpr_pkg: state enum type, default NUM_REGS/DATA_WIDTH, FIRST_REG=1 constant.
- One sub-module: sat_counter (parameterised width, increment enable, synchronous reset) for rec_count_o.
- FSM, index counter, wdata_q capture register and pending flag in sgpr_restore.

## Test plan

- Reset: rst high 2 cycles with error_i=1 -> all outputs zero, state IDLE, no halt.
- Basic restore: GPR xN preloaded with 100+N, acks high, error_i pulse cycle 0 -> 31 writes x1..x31 data 101..131 in order, done_o at cycle 95, rec_count_o=1.
- Backpressure: wr_ready_i low 3 cycles on x11 write -> we_o/waddr_o=11/wdata_o=111 held stable, done_o delayed by exactly 3 cycles.
- Halt handshake: halt_ack_i delayed 5 cycles -> no raddr_o activity, halt_o=1 throughout, first READ cycle after ack.
- Error during restore: error_i pulse while writing x10 -> after DONE, second full pass without returning to IDLE, rec_count_o=2, halt_o held high continuously.
- Reset mid-operation: rst at x20 write -> next cycle we_o=0, halt_o=0, IDLE; later error_i starts again at x1.

Source files
------------

// File: rtl/sgpr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sgpr_pkg
// Description : Shared types and constants for the GPR restore sequencer.
//               Holds the sequencer state encoding, the default register
//               file geometry and the index of the first restored register.
// Revision    : 1.0  initial release
// ============================================================================
package sgpr_pkg;

    // Default register file geometry
    localparam int c_NUM_REGS   = 32;
    localparam int c_DATA_WIDTH = 32;

    // x0 is hard-wired to zero in the cores, so the restore starts at x1
    localparam int c_FIRST_REG  = 1;

    // Sequencer states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HALT    = 3'd1,
        ST_READ    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_WRITE   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage : sgpr_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
//               Used to count completed GPR restore passes.
// Ports       : clk      - clock, rising edge
//               rst      - synchronous active-high reset, clears the count
//               i_inc    - add one to the count this cycle (if not saturated)
//               o_count  - current count value
// Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/sgpr_restore.sv
`default_nettype none
// ============================================================================
// Module      : sgpr_restore
// Description : Recovery sequencer for the shared comparing GPR file. On a
//               lockstep mismatch it halts both cores, reads x1..x(N-1) back
//               from the shared GPR and replays each value into the cores'
//               local register files over a ready-handshaked write port.
//               A mismatch seen while a pass is running is remembered and
//               causes one more complete pass straight after the current one.
// Ports       : clk          - clock, rising edge
//               rst          - synchronous active-high reset
//               error_i      - comparator mismatch flag
//               halt_ack_i   - both cores report halted
//               raddr_o      - shared GPR read address
//               rdata_i      - shared GPR read data (one cycle after raddr_o)
//               we_o         - restore write valid
//               waddr_o      - restore write address
//               wdata_o      - restore write data
//               wr_ready_i   - cores accept the restore write
//               halt_o       - hold both cores
//               busy_o       - a restore sequence is in progress
//               done_o       - one-cycle pulse at the end of a pass
//               rec_count_o  - number of completed passes, saturating
// Revision    : 1.0  initial release
// ============================================================================
module sgpr_restore
    import sgpr_pkg::*;
#(
    parameter int NUM_REGS   = c_NUM_REGS,
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  error_i,
    input  logic                  halt_ack_i,
    output logic [ADDR_WIDTH-1:0] raddr_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    input  logic                  wr_ready_i,
    output logic                  halt_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  rec_count_o
);

    localparam logic [ADDR_WIDTH-1:0] c_FIRST_IDX = ADDR_WIDTH'(c_FIRST_REG);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [DATA_WIDTH-1:0] r_wdata_q;
    logic                  r_pending_q;
    logic                  w_restart;
    logic                  w_last_accept;

    // A pass restarts from DONE if a mismatch was latched during the pass,
    // or if one arrives in the DONE cycle itself; either way the cores stay
    // halted and no second trip through IDLE is needed.
    assign w_restart     = r_pending_q || error_i;
    assign w_last_accept = wr_ready_i && (r_idx == c_LAST_IDX);

    // ------------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= c_FIRST_IDX;
            r_wdata_q   <= '0;
            r_pending_q <= 1'b0;
        end else begin
            r_state <= w_next_state;

            // Register index: rewound at the start of every pass, stepped
            // only when the cores have taken the current write.
            case (r_state)
                ST_IDLE: begin
                    if (error_i) begin
                        r_idx <= c_FIRST_IDX;
                    end
                end
                ST_WRITE: begin
                    if (wr_ready_i && !w_last_accept) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_restart) begin
                        r_idx <= c_FIRST_IDX;
                    end
                end
                default: begin
                end
            endcase

            // The read data arrives one cycle after the address was
            // presented, i.e. during CAPTURE. Holding it here keeps wdata_o
            // stable for as long as the write is back-pressured.
            if (r_state == ST_CAPTURE) begin
                r_wdata_q <= rdata_i;
            end

            // Pending flag: consumed in DONE, otherwise set by any mismatch
            // outside IDLE (an IDLE mismatch starts the pass directly).
            if (r_state == ST_DONE) begin
                r_pending_q <= 1'b0;
            end else if ((r_state != ST_IDLE) && error_i) begin
                r_pending_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (error_i) begin
                    w_next_state = ST_HALT;
                end
            end
            ST_HALT: begin
                if (halt_ack_i) begin
                    w_next_state = ST_READ;
                end
            end
            ST_READ: begin
                w_next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_next_state = ST_WRITE;
            end
            ST_WRITE: begin
                if (wr_ready_i) begin
                    w_next_state = w_last_accept ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                w_next_state = w_restart ? ST_HALT : ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded from registered state, index and captured data only,
    // so no input reaches an output combinationally.
    // ------------------------------------------------------------------------
    always_comb begin
        raddr_o = '0;
        we_o    = 1'b0;
        waddr_o = '0;
        wdata_o = '0;
        halt_o  = (r_state != ST_IDLE);
        busy_o  = (r_state != ST_IDLE);
        done_o  = (r_state == ST_DONE);
        case (r_state)
            ST_READ: begin
                raddr_o = r_idx;
            end
            ST_WRITE: begin
                we_o    = 1'b1;
                waddr_o = r_idx;
                wdata_o = r_wdata_q;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Completed-pass counter
    // ------------------------------------------------------------------------
    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_rec_count (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (r_state == ST_DONE),
        .o_count (rec_count_o)
    );

endmodule : sgpr_restore
`default_nettype wire

// File: tb/tb_sgpr_restore.sv
`default_nettype none
// ============================================================================
// Module      : tb_sgpr_restore
// Description : Self-checking bench for sgpr_restore. The bench owns a model
//               of the shared GPR contents; every started pass queues the 31
//               expected writes and the expected pass count, and a monitor
//               compares each accepted write and each done pulse against
//               those queues. Directed scenarios also check cycle timing.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sgpr_restore;

    localparam int c_NR = 32;

    logic        clk;
    logic        rst;
    logic        error_i;
    logic        halt_ack_i;
    logic [4:0]  raddr_o;
    logic [31:0] rdata_i;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        wr_ready_i;
    logic        halt_o;
    logic        busy_o;
    logic        done_o;
    logic [7:0]  rec_count_o;

    sgpr_restore dut (
        .clk         (clk),
        .rst         (rst),
        .error_i     (error_i),
        .halt_ack_i  (halt_ack_i),
        .raddr_o     (raddr_o),
        .rdata_i     (rdata_i),
        .we_o        (we_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .wr_ready_i  (wr_ready_i),
        .halt_o      (halt_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rec_count_o (rec_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared GPR model: synchronous read, data one cycle after address
    logic [31:0] mem [c_NR];
    always @(posedge clk) rdata_i <= mem[raddr_o];

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    int  model_rec;
    int  total;
    int  bad;

    // responder configuration
    bit  rdy_rand;
    bit  ack_rand;
    int  ack_delay_cfg;
    int  ack_wait;
    bit  prev_halt;
    int  stall_addr;
    int  stall_left;
    int  inj_at;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One restore pass: x1..x31 in order with the current GPR contents
    task automatic push_pass();
        wr_t w;
        for (int r = 1; r < c_NR; r++) begin
            w.a = 5'(r);
            w.d = mem[r];
            wq.push_back(w);
        end
        model_rec = (model_rec < 255) ? model_rec + 1 : 255;
        dq.push_back(model_rec);
    endtask

    // Advance one cycle and drive the responder inputs for the new cycle
    task automatic step();
        int k;
        @(negedge clk);
        error_i = 1'b0;
        if (halt_o && !prev_halt) ack_wait = ack_delay_cfg;
        prev_halt = halt_o;
        if (ack_rand) begin
            halt_ack_i = ($urandom_range(0, 2) != 0);
        end else if (ack_wait > 0) begin
            halt_ack_i = 1'b0;
            ack_wait--;
        end else begin
            halt_ack_i = 1'b1;
        end
        if (rdy_rand) begin
            wr_ready_i = ($urandom_range(0, 3) != 0);
        end else if (we_o && (waddr_o == 5'(stall_addr)) && (stall_left > 0)) begin
            wr_ready_i = 1'b0;
            stall_left--;
        end else begin
            wr_ready_i = 1'b1;
        end
        // Mid-pass mismatch: raised in the cycle x_k is accepted. The current
        // pass still holds 32-k queued writes; a second pass is owed unless
        // one is already queued behind it.
        if (inj_at != 0 && we_o && wr_ready_i && (waddr_o == 5'(inj_at))) begin
            k = inj_at;
            inj_at = 0;
            error_i = 1'b1;
            if (wq.size() <= 32 - k) push_pass();
        end
    endtask

    task automatic wait_idle(input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            step();
            if (wq.size() == 0 && dq.size() == 0 && !busy_o) ok = 1'b1;
        end
        if (!ok) check("drain_timeout", wq.size() + dq.size(), 0);
        step();
    endtask

    task automatic start_pass();
        error_i = 1'b1;
        push_pass();
    endtask

    // ---------------- monitor ----------------
    bit          in_stall;
    logic [4:0]  st_a;
    logic [31:0] st_d;
    bit          rc_pending;
    int          rc_exp;
    int          writes_since;

    always @(negedge clk) begin
        wr_t e;
        #2;
        if (rst) begin
            in_stall     = 1'b0;
            rc_pending   = 1'b0;
            writes_since = 0;
        end else begin
            if (rc_pending) begin
                check("rec_count", rec_count_o, rc_exp);
                rc_pending = 1'b0;
            end
            if (in_stall) begin
                check("stall_we_held", we_o, 1);
                check("stall_waddr_held", waddr_o, st_a);
                check("stall_wdata_held", wdata_o, st_d);
            end
            in_stall = 1'b0;
            if (we_o) begin
                if (wr_ready_i) begin
                    check("write_expected", wq.size() > 0, 1);
                    if (wq.size() > 0) begin
                        e = wq.pop_front();
                        check("waddr", waddr_o, e.a);
                        check("wdata", wdata_o, e.d);
                    end
                    writes_since++;
                end else begin
                    in_stall = 1'b1;
                    st_a     = waddr_o;
                    st_d     = wdata_o;
                end
            end
            if (done_o) begin
                check("done_expected", dq.size() > 0, 1);
                if (dq.size() > 0) begin
                    rc_exp     = dq.pop_front();
                    rc_pending = 1'b1;
                end
                check("writes_per_pass", writes_since, 31);
                writes_since = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : main
        int c, first_w, done_c, done2_c, halt_gap, early_rd, first_rd, first_ra;
        bit found;
        total = 0; bad = 0; model_rec = 0;
        rst = 1'b1; error_i = 1'b1; halt_ack_i = 1'b1; wr_ready_i = 1'b1;
        rdy_rand = 0; ack_rand = 0; ack_delay_cfg = 0; ack_wait = 0;
        prev_halt = 0; stall_addr = 0; stall_left = 0; inj_at = 0;
        for (int r = 0; r < c_NR; r++) mem[r] = 32'(100 + r);

        // Reset with error asserted
        step(); error_i = 1'b1;
        step();
        check("rst_we", we_o, 0);
        check("rst_raddr", raddr_o, 0);
        check("rst_waddr", waddr_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_halt", halt_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_count", rec_count_o, 0);
        rst = 1'b0;
        step(); step();
        check("post_rst_idle", busy_o, 0);

        // Basic restore timing
        start_pass();
        c = 0; first_w = -1; done_c = -1;
        for (int i = 0; i < 400 && done_c < 0; i++) begin
            step(); c++;
            if (we_o && first_w < 0) first_w = c;
            if (done_o) done_c = c;
        end
        check("basic_first_write_cycle", first_w, 4);
        check("basic_done_cycle", done_c, 95);
        step();
        check("basic_halt_low_after_done", halt_o, 0);
        wait_idle(50);

        // Backpressure on x11 for 3 cycles
        stall_addr = 11; stall_left = 3;
        start_pass();
        c = 0; done_c = -1;
        for (int i = 0; i < 400 && done_c < 0; i++) begin
            step(); c++;
            if (done_o) done_c = c;
        end
        check("bp_done_cycle", done_c, 98);
        wait_idle(50);

        // Delayed halt acknowledge
        ack_delay_cfg = 5;
        start_pass();
        c = 0; done_c = -1; early_rd = 0; first_rd = -1; first_ra = -1; halt_gap = 0;
        for (int i = 0; i < 400 && done_c < 0; i++) begin
            step(); c++;
            if (c <= 6 && raddr_o != 0) early_rd++;
            if (raddr_o != 0 && first_rd < 0) begin first_rd = c; first_ra = int'(raddr_o); end
            if (!halt_o) halt_gap++;
            if (done_o) done_c = c;
        end
        check("ack_no_early_read", early_rd, 0);
        check("ack_first_read_cycle", first_rd, 7);
        check("ack_first_read_addr", first_ra, 1);
        check("ack_halt_held", halt_gap, 0);
        check("ack_done_cycle", done_c, 100);
        ack_delay_cfg = 0;
        wait_idle(50);

        // Mismatch during the x10 write -> second pass back to back
        inj_at = 10;
        start_pass();
        c = 0; done_c = -1; done2_c = -1; halt_gap = 0;
        for (int i = 0; i < 600 && done2_c < 0; i++) begin
            step(); c++;
            if (!halt_o) halt_gap++;
            if (done_o) begin
                if (done_c < 0) done_c = c; else done2_c = c;
            end
        end
        check("err_first_done", done_c, 95);
        check("err_second_done", done2_c, 190);
        check("err_halt_continuous", halt_gap, 0);
        wait_idle(50);

        // Reset while x20 is being written
        start_pass();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (we_o && waddr_o == 5'd20) found = 1'b1;
        end
        check("reached_x20", found, 1);
        rst = 1'b1;
        wq.delete(); dq.delete(); model_rec = 0;
        step();
        check("midrst_we", we_o, 0);
        check("midrst_halt", halt_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_count", rec_count_o, 0);
        rst = 1'b0;
        step(); step();
        check("midrst_stays_idle", busy_o, 0);
        start_pass();
        wait_idle(300);

        // Randomised passes with random contents, handshakes and mid-pass errors
        for (int it = 0; it < 12; it++) begin
            for (int r = 0; r < c_NR; r++) mem[r] = $urandom;
            rdy_rand = 1'($urandom_range(0, 1));
            ack_rand = 1'($urandom_range(0, 1));
            inj_at   = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 28)) : 0;
            start_pass();
            wait_idle(3000);
            inj_at = 0;
        end
        rdy_rand = 0; ack_rand = 0;

        // Drive the pass counter into saturation
        for (int r = 0; r < c_NR; r++) mem[r] = 32'(100 + r);
        for (int it = 0; it < 258; it++) begin
            start_pass();
            wait_idle(300);
        end
        check("sat_count", rec_count_o, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sgpr_restore
`default_nettype wire
